// File: rtl/shared_data_memory_if.sv
// Core-side request bus of the shared data memory: per-port request fields,
// one-hot grant/read-valid strobes and the shared registered read data bus.
interface shared_data_memory_if #(
  parameter int NUM_PORTS = 8,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8
);
  logic [NUM_PORTS-1:0]        req;
  logic [NUM_PORTS-1:0]        we;
  logic [NUM_PORTS*ADDR_W-1:0] addr;
  logic [NUM_PORTS*DATA_W-1:0] wdata;
  logic [NUM_PORTS-1:0]        gnt;
  logic [NUM_PORTS-1:0]        rvalid;
  logic [DATA_W-1:0]           rdata;
  logic                        busy;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, busy
  );
endinterface

// File: rtl/shared_data_memory.sv
// Multi-port shared data memory: round-robin arbiter, one access per cycle,
// registered read path, and a zero-fill sequence after every reset.
module shared_data_memory #(
  parameter int NUM_PORTS = 8,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  shared_data_memory_if.slave   bus
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  typedef enum logic {INIT, RUN} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   cnt_reg, cnt_next;
  logic [PTR_W-1:0]   rr_reg, rr_next;
  logic [NUM_PORTS-1:0] rvalid_reg;
  logic [DATA_W-1:0]  rdata_reg;

  logic [DATA_W-1:0]  mem [DEPTH];

  logic [ADDR_W-1:0]  addr_arr  [NUM_PORTS];
  logic [DATA_W-1:0]  wdata_arr [NUM_PORTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
      assign addr_arr[gi]  = bus.addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = bus.wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Round-robin search starting at rr_reg, wrapping modulo NUM_PORTS.
  logic [NUM_PORTS-1:0] gnt_c;
  logic [PTR_W-1:0]     win_idx;
  logic                 win_found;
  logic [PTR_W:0]       scan_idx;
  logic                 grant_valid;

  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    scan_idx  = '0;
    gnt_c     = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      scan_idx = {1'b0, rr_reg} + (PTR_W+1)'(k);
      if (scan_idx >= (PTR_W+1)'(NUM_PORTS)) begin
        scan_idx = scan_idx - (PTR_W+1)'(NUM_PORTS);
      end
      if (!win_found && bus.req[scan_idx[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[PTR_W-1:0];
      end
    end
    if (state_reg == RUN && !rst && win_found) begin
      gnt_c[win_idx] = 1'b1;
    end
  end

  assign grant_valid = (state_reg == RUN) && !rst && win_found;

  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_in_range;

  assign sel_we       = bus.we[win_idx];
  assign sel_addr     = addr_arr[win_idx];
  assign sel_wdata    = wdata_arr[win_idx];
  assign sel_idx      = sel_addr[IDX_W-1:0];
  assign sel_in_range = {{(32-ADDR_W){1'b0}}, sel_addr} < DEPTH_U;

  // Single write port shared by the zero-fill and granted core writes.
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic [DATA_W-1:0]  wr_data;

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    if (state_reg == INIT && !rst) begin
      wr_en  = 1'b1;
      wr_idx = cnt_reg;
    end else if (grant_valid && sel_we && sel_in_range) begin
      wr_en   = 1'b1;
      wr_idx  = sel_idx;
      wr_data = sel_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_reg <= '0;
      rdata_reg  <= '0;
    end else if (grant_valid && !sel_we) begin
      rvalid_reg <= gnt_c;
      rdata_reg  <= sel_in_range ? mem[sel_idx] : '0;
    end else begin
      rvalid_reg <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= INIT;
      cnt_reg   <= '0;
      rr_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rr_reg    <= rr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rr_next    = rr_reg;
    case (state_reg)
      INIT: begin
        cnt_next = cnt_reg + IDX_W'(1);
        if (cnt_reg == IDX_W'(DEPTH-1)) begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      RUN: begin
        if (grant_valid) begin
          rr_next = (int'(win_idx) == NUM_PORTS-1) ? '0 : win_idx + PTR_W'(1);
        end
      end
      default: state_next = INIT;
    endcase
  end

  assign bus.gnt    = gnt_c;
  assign bus.rvalid = rvalid_reg;
  assign bus.rdata  = rdata_reg;
  assign bus.busy   = (state_reg == INIT);

endmodule

// File: tb/tb_shared_data_memory.sv
// Randomised and directed bench for shared_data_memory against a behavioural
// model (memory array, round-robin distance rule, fill countdown).
module tb_shared_data_memory;

  localparam int N  = 8;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int D  = 256;

  logic clk;
  logic rst;
  logic rst2;

  shared_data_memory_if #(.NUM_PORTS(N), .DATA_W(DW), .ADDR_W(AW)) bus ();
  shared_data_memory_if #(.NUM_PORTS(N), .DATA_W(DW), .ADDR_W(AW)) bus2 ();

  shared_data_memory #(.NUM_PORTS(N), .DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  shared_data_memory #(.NUM_PORTS(N), .DATA_W(DW), .ADDR_W(AW), .DEPTH(200)) u_dut_oor (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int          m_mem [D];
  int          m_rr;
  logic [N-1:0] m_rv;
  logic [DW-1:0] m_rd;
  int          m_fill;

  // Winner = requester with the smallest forward distance from the pointer.
  function automatic int pick();
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = N;
    if (rst === 1'b1 || m_fill > 0) return -1;
    for (int i = 0; i < N; i++) begin
      if (bus.req[i] === 1'b1) begin
        d = (i - m_rr + N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic model_edge();
    int w;
    int a;
    w = pick();
    if (rst === 1'b1) begin
      for (int i = 0; i < D; i++) m_mem[i] = 0;
      m_rr = 0; m_rv = '0; m_rd = '0; m_fill = D;
    end else if (m_fill > 0) begin
      m_fill = m_fill - 1;
      m_rv   = '0;
    end else if (w < 0) begin
      m_rv = '0;
    end else begin
      a = int'(bus.addr[w*AW +: AW]);
      if (bus.we[w] === 1'b1) begin
        if (a < D) m_mem[a] = int'(bus.wdata[w*DW +: DW]);
        m_rv = '0;
        $display("txn port %0d write addr %0d data %0h", w, a, bus.wdata[w*DW +: DW]);
      end else begin
        m_rv = N'(1) << w;
        m_rd = (a < D) ? DW'(m_mem[a]) : '0;
        $display("txn port %0d read  addr %0d data %0h", w, a, m_rd);
      end
      m_rr = (w + 1) % N;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req[p]            = r;
    bus.we[p]             = w;
    bus.addr[p*AW +: AW]  = a;
    bus.wdata[p*DW +: DW] = d;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    repeat (2) tick();
    @(negedge clk);
    n_checks++; if (bus.gnt !== '0) begin n_errors++; $display("FAIL reset_gnt: got %h expected 00", bus.gnt); end
    n_checks++; if (bus.rvalid !== '0) begin n_errors++; $display("FAIL reset_rvalid: got %h expected 00", bus.rvalid); end
    n_checks++; if (bus.rdata !== '0) begin n_errors++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata); end
    n_checks++; if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL reset_busy: got %b expected 1", bus.busy); end
    rst = 1'b0;
    n = 0;
    while (n < 1000) begin
      if (bus.busy !== 1'b1) break;
      n++;
      tick();
      @(negedge clk);
    end
    n_checks++; if (n !== D) begin n_errors++; $display("FAIL fill_length: got %0d busy cycles expected %0d", n, D); end
    tick();
  endtask

  task automatic test_fill_reads();
    set_port(0, 1'b1, 1'b0, 8'd0, 16'h0);
    set_port(7, 1'b1, 1'b0, 8'd255, 16'h0);
    @(negedge clk);
    n_checks++; if (bus.gnt !== 8'h01) begin n_errors++; $display("FAIL fill_rd_gnt0: got %h expected 01", bus.gnt); end
    tick();
    bus.req[0] = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.gnt !== 8'h80) begin n_errors++; $display("FAIL fill_rd_gnt7: got %h expected 80", bus.gnt); end
    n_checks++; if (bus.rvalid !== 8'h01 || bus.rdata !== 16'h0) begin n_errors++; $display("FAIL fill_rd_a0: got rvalid %h rdata %h expected 01/0000", bus.rvalid, bus.rdata); end
    tick();
    bus.req = '0;
    @(negedge clk);
    n_checks++; if (bus.rvalid !== 8'h80 || bus.rdata !== 16'h0) begin n_errors++; $display("FAIL fill_rd_a255: got rvalid %h rdata %h expected 80/0000", bus.rvalid, bus.rdata); end
    tick();
  endtask

  task automatic test_round_robin();
    int last [N];
    logic [N-1:0] exp_g;
    for (int p = 0; p < N; p++) begin
      set_port(p, 1'b1, 1'b0, AW'(p * 3), 16'h0);
      last[p] = -1;
    end
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      exp_g = N'(1) << (k % N);
      n_checks++; if (bus.gnt !== exp_g) begin n_errors++; $display("FAIL rr_gnt[%0d]: got %h expected %h", k, bus.gnt, exp_g); end
      n_checks++; if (bus.rvalid !== m_rv || bus.rdata !== m_rd) begin n_errors++; $display("FAIL rr_rdata[%0d]: got %h/%h expected %h/%h", k, bus.rvalid, bus.rdata, m_rv, m_rd); end
      for (int p = 0; p < N; p++) begin
        if (bus.gnt[p] === 1'b1) begin
          if (last[p] >= 0) begin
            n_checks++; if (k - last[p] !== N) begin n_errors++; $display("FAIL rr_fair port %0d: got gap %0d expected %0d", p, k - last[p], N); end
          end
          last[p] = k;
        end
      end
      tick();
    end
    bus.req = '0;
    tick();
  endtask

  task automatic test_single_port();
    set_port(3, 1'b1, 1'b1, 8'd14, 16'd23);
    @(negedge clk);
    n_checks++; if (bus.gnt !== 8'h08) begin n_errors++; $display("FAIL sp_wr_gnt: got %h expected 08", bus.gnt); end
    tick();
    set_port(3, 1'b1, 1'b0, 8'd14, 16'd0);
    @(negedge clk);
    n_checks++; if (bus.gnt !== 8'h08) begin n_errors++; $display("FAIL sp_rd_gnt: got %h expected 08", bus.gnt); end
    tick();
    bus.req = '0;
    @(negedge clk);
    n_checks++; if (bus.rvalid !== 8'h08 || bus.rdata !== 16'd23) begin n_errors++; $display("FAIL sp_rdata: got %h/%0d expected 08/23", bus.rvalid, bus.rdata); end
    tick();
  endtask

  task automatic test_coherence();
    set_port(1, 1'b1, 1'b1, 8'd15, 16'd2);
    set_port(2, 1'b1, 1'b0, 8'd15, 16'd0);
    @(negedge clk);
    n_checks++; if (bus.gnt !== 8'h02) begin n_errors++; $display("FAIL coh_wr_gnt: got %h expected 02", bus.gnt); end
    tick();
    bus.req[1] = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.gnt !== 8'h04) begin n_errors++; $display("FAIL coh_rd_gnt: got %h expected 04", bus.gnt); end
    tick();
    bus.req = '0;
    @(negedge clk);
    n_checks++; if (bus.rvalid !== 8'h04 || bus.rdata !== 16'd2) begin n_errors++; $display("FAIL coh_rdata: got %h/%0d expected 04/2", bus.rvalid, bus.rdata); end
    tick();
  endtask

  task automatic test_random();
    int w;
    int waitc [N];
    logic [N-1:0] exp_g;
    bus.req = '0;
    for (int p = 0; p < N; p++) waitc[p] = 0;
    for (int c = 0; c < 300; c++) begin
      for (int p = 0; p < N; p++) begin
        if (bus.req[p] !== 1'b1 && $urandom_range(1, 0) == 1) begin
          set_port(p, 1'b1, 1'($urandom_range(1, 0)), 8'($urandom_range(31, 0)), 16'($urandom));
        end
      end
      @(negedge clk);
      w = pick();
      exp_g = (w < 0) ? '0 : (N'(1) << w);
      n_checks++; if (bus.gnt !== exp_g) begin n_errors++; $display("FAIL rnd_gnt[%0d]: got %h expected %h", c, bus.gnt, exp_g); end
      n_checks++; if (bus.rvalid !== m_rv) begin n_errors++; $display("FAIL rnd_rvalid[%0d]: got %h expected %h", c, bus.rvalid, m_rv); end
      n_checks++; if (bus.rdata !== m_rd) begin n_errors++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", c, bus.rdata, m_rd); end
      for (int p = 0; p < N; p++) begin
        if (bus.req[p] === 1'b1) begin
          if (p == w) begin
            n_checks++; if (waitc[p] > N - 1) begin n_errors++; $display("FAIL rnd_starve port %0d: got wait %0d expected <= %0d", p, waitc[p], N - 1); end
            waitc[p] = 0;
          end else begin
            waitc[p]++;
          end
        end
      end
      tick();
      if (w >= 0) bus.req[w] = 1'b0;
    end
    bus.req = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    set_port(0, 1'b1, 1'b1, 8'd14, 16'd23);
    tick();
    set_port(0, 1'b1, 1'b0, 8'd14, 16'd0);
    @(negedge clk);
    n_checks++; if (bus.gnt !== 8'h01) begin n_errors++; $display("FAIL rm_rd_gnt: got %h expected 01", bus.gnt); end
    tick();
    bus.req = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.rvalid !== '0) begin n_errors++; $display("FAIL rm_rvalid: got %h expected 00", bus.rvalid); end
    n = 0;
    while (n < 1000) begin
      if (bus.busy !== 1'b1) break;
      n++;
      tick();
      @(negedge clk);
    end
    n_checks++; if (n !== D) begin n_errors++; $display("FAIL rm_fill_length: got %0d expected %0d", n, D); end
    tick();
    set_port(0, 1'b1, 1'b0, 8'd14, 16'd0);
    @(negedge clk);
    n_checks++; if (bus.gnt !== 8'h01) begin n_errors++; $display("FAIL rm_reread_gnt: got %h expected 01", bus.gnt); end
    tick();
    bus.req = '0;
    @(negedge clk);
    n_checks++; if (bus.rvalid !== 8'h01 || bus.rdata !== 16'd0) begin n_errors++; $display("FAIL rm_reread: got %h/%0d expected 01/0", bus.rvalid, bus.rdata); end
    tick();
  endtask

  task automatic test_out_of_range();
    int n;
    bus2.req = 8'h20; bus2.we = '0; bus2.addr = '0; bus2.wdata = '0;
    bus2.addr[5*AW +: AW] = 8'd3;
    rst2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst2 = 1'b0;
    @(negedge clk);
    n = 0;
    while (n < 1000) begin
      if (bus2.busy !== 1'b1) break;
      n++;
      n_checks++; if (bus2.gnt !== '0) begin n_errors++; $display("FAIL oor_init_gnt: got %h expected 00", bus2.gnt); end
      @(negedge clk);
    end
    n_checks++; if (n !== 200) begin n_errors++; $display("FAIL oor_fill_length: got %0d expected 200", n); end
    n_checks++; if (bus2.gnt !== 8'h20) begin n_errors++; $display("FAIL oor_first_run_gnt: got %h expected 20", bus2.gnt); end
    @(posedge clk); #1;
    bus2.req = 8'h01; bus2.we = 8'h01;
    bus2.addr[0 +: AW] = 8'd199; bus2.wdata[0 +: DW] = 16'd77;
    @(negedge clk);
    n_checks++; if (bus2.rvalid !== 8'h20 || bus2.rdata !== 16'd0) begin n_errors++; $display("FAIL oor_held_read: got %h/%0d expected 20/0", bus2.rvalid, bus2.rdata); end
    @(posedge clk); #1;
    bus2.addr[0 +: AW] = 8'd210; bus2.wdata[0 +: DW] = 16'd5;
    @(negedge clk);
    n_checks++; if (bus2.gnt !== 8'h01) begin n_errors++; $display("FAIL oor_wr_gnt: got %h expected 01", bus2.gnt); end
    @(posedge clk); #1;
    bus2.we = 8'h00; bus2.addr[0 +: AW] = 8'd199;
    @(posedge clk); #1;
    bus2.addr[0 +: AW] = 8'd210;
    @(negedge clk);
    n_checks++; if (bus2.rvalid !== 8'h01 || bus2.rdata !== 16'd77) begin n_errors++; $display("FAIL oor_last_word: got %h/%0d expected 01/77", bus2.rvalid, bus2.rdata); end
    n_checks++; if (bus2.gnt !== 8'h01) begin n_errors++; $display("FAIL oor_rd_gnt: got %h expected 01", bus2.gnt); end
    @(posedge clk); #1;
    bus2.req = '0;
    @(negedge clk);
    n_checks++; if (bus2.rvalid !== 8'h01 || bus2.rdata !== 16'd0) begin n_errors++; $display("FAIL oor_read: got %h/%0d expected 01/0", bus2.rvalid, bus2.rdata); end
  endtask

  initial begin
    rst  = 1'b1;
    rst2 = 1'b1;
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    bus2.req = '0; bus2.we = '0; bus2.addr = '0; bus2.wdata = '0;
    for (int i = 0; i < D; i++) m_mem[i] = 0;
    m_rr = 0; m_rv = '0; m_rd = '0; m_fill = D;
    #1;
    test_reset();
    test_fill_reads();
    test_round_robin();
    test_single_port();
    test_coherence();
    test_random();
    test_reset_mid();
    test_out_of_range();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
